// File: rtl/seq_mult.sv
// Iterative shift-add multiplier with start/done handshake, unsigned and signed modes.
// Define SEQ_MULT_EARLY_EXIT_EN to leave CALC once the remaining multiplier bits are zero.
module seq_mult #(
   parameter int unsigned WIDTH = 16
) (
   input  logic               clk,
   input  logic               n_rst,
   input  logic               start,
   input  logic               signed_op,
   input  logic [WIDTH-1:0]   src1,
   input  logic [WIDTH-1:0]   src2,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] calc_res
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIX
   } state_t;

   state_t             r_state;
   logic [2*WIDTH-1:0] r_acc;
   logic [2*WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0]   r_mplr;
   logic [CW-1:0]      r_cnt;
   logic               r_neg;
   logic               r_busy;
   logic               r_done;
   logic [2*WIDTH-1:0] r_res;

   logic [WIDTH-1:0]   w_mag1;
   logic [WIDTH-1:0]   w_mag2;
   logic [WIDTH-1:0]   w_mplr_nxt;
   logic [2*WIDTH-1:0] w_sum;
   logic               w_last;

   // Negating the most negative value wraps to itself, which read unsigned is the exact magnitude.
   assign w_mag1     = (signed_op && src1[WIDTH-1]) ? -src1 : src1;
   assign w_mag2     = (signed_op && src2[WIDTH-1]) ? -src2 : src2;
   assign w_mplr_nxt = r_mplr >> 1;
   assign w_sum      = r_mplr[0] ? (r_acc + r_mcand) : r_acc;

`ifdef SEQ_MULT_EARLY_EXIT_EN
   assign w_last = (r_cnt == CW'(WIDTH - 1)) || (w_mplr_nxt == '0);
`else
   assign w_last = (r_cnt == CW'(WIDTH - 1));
`endif

   always_ff @(posedge clk or posedge n_rst) begin
      if (n_rst) begin
         r_state <= S_IDLE;
         r_acc   <= '0;
         r_mcand <= '0;
         r_mplr  <= '0;
         r_cnt   <= '0;
         r_neg   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_res   <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_acc   <= '0;
                  r_cnt   <= '0;
                  r_mcand <= {{WIDTH{1'b0}}, w_mag1};
                  r_mplr  <= w_mag2;
                  r_neg   <= signed_op & (src1[WIDTH-1] ^ src2[WIDTH-1]);
                  r_busy  <= 1'b1;
                  r_state <= S_CALC;
               end
            end
            S_CALC: begin
               r_acc   <= w_sum;
               r_mcand <= r_mcand << 1;
               r_mplr  <= w_mplr_nxt;
               r_cnt   <= r_cnt + 1'b1;
               if (w_last) begin
                  r_state <= S_FIX;
               end
            end
            S_FIX: begin
               r_res   <= r_neg ? -r_acc : r_acc;
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy     = r_busy;
   assign done     = r_done;
   assign calc_res = r_res;

endmodule

// File: tb/tb_seq_mult.sv
// Randomised self-checking bench for seq_mult (WIDTH=16) against an arithmetic reference model.
// Honours SEQ_MULT_EARLY_EXIT_EN for the expected latency.
module tb_seq_mult;

   localparam int unsigned W = 16;

   logic           clk;
   logic           n_rst;
   logic           start;
   logic           signed_op;
   logic [W-1:0]   src1;
   logic [W-1:0]   src2;
   logic           busy;
   logic           done;
   logic [2*W-1:0] calc_res;

   int unsigned    n_vec;
   int unsigned    n_err;
   logic [2*W-1:0] last_res;

   seq_mult #(.WIDTH(W)) u_dut (
      .clk       (clk),
      .n_rst     (n_rst),
      .start     (start),
      .signed_op (signed_op),
      .src1      (src1),
      .src2      (src2),
      .busy      (busy),
      .done      (done),
      .calc_res  (calc_res)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic s);
      longint pa;
      longint pb;
      longint p;
      logic [63:0] pv;
      pa = s ? longint'($signed(a)) : longint'({48'd0, a});
      pb = s ? longint'($signed(b)) : longint'({48'd0, b});
      p  = pa * pb;
      pv = p;
      return pv[2*W-1:0];
   endfunction

   function automatic int ref_lat(input logic [W-1:0] b, input logic s);
`ifdef SEQ_MULT_EARLY_EXIT_EN
      int m;
      int mag;
      mag = (s && b[W-1]) ? (65536 - int'(b)) : int'(b);
      if (mag == 0) return 2;
      m = 0;
      for (int i = 0; i < 17; i++) if ((mag >> i) != 0) m = i;
      return m + 2;
`else
      return int'(W) + 1 + 0 * int'(s) + 0 * int'(b[0]);
`endif
   endfunction

   // intr > 0 drives a second start (9x9) sampled at that edge while busy
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input int intr);
      logic [2*W-1:0] exp;
      int lat;
      int edges;
      bit got;
      exp = ref_prod(a, b, s);
      lat = ref_lat(b, s);
      start = 1'b1; signed_op = s; src1 = a; src2 = b;
      @(posedge clk); #1;
      start = 1'b0; src1 = W'($urandom); src2 = W'($urandom); signed_op = 1'($urandom);
      chk("busy_after_start", {63'd0, busy}, 64'd1);
      edges = 0;
      got   = 0;
      while (!got && edges < int'(W) + 8) begin
         if (intr > 0 && edges + 1 == intr) begin
            start = 1'b1; src1 = 16'd9; src2 = 16'd9; signed_op = 1'b0;
         end
         @(posedge clk); #1;
         start = 1'b0;
         edges++;
         if (edges < lat) begin
            chk("busy_calc", {63'd0, busy}, 64'd1);
            chk("done_early", {63'd0, done}, 64'd0);
            chk("res_held", {32'd0, calc_res}, {32'd0, last_res});
         end else begin
            chk("done_pulse", {63'd0, done}, 64'd1);
            chk("busy_low_at_done", {63'd0, busy}, 64'd0);
            chk("result", {32'd0, calc_res}, {32'd0, exp});
            got = 1;
         end
      end
      if (!got) chk("done_timeout", 64'd0, 64'd1);
      last_res = exp;
   endtask

   task automatic idle_chk(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         chk("idle_done", {63'd0, done}, 64'd0);
         chk("idle_busy", {63'd0, busy}, 64'd0);
         chk("idle_res", {32'd0, calc_res}, {32'd0, last_res});
      end
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 7))
         0: return '0;
         1: return 16'h8000;
         2: return 16'hFFFF;
         3: return 16'h0001;
         4: return 16'h7FFF;
         default: return W'($urandom);
      endcase
   endfunction

   initial begin
      n_vec = 0; n_err = 0; last_res = '0;
      n_rst = 1'b1; start = 1'b0; signed_op = 1'b0; src1 = '0; src2 = '0;
      #12;
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_res", {32'd0, calc_res}, 64'd0);
      @(negedge clk); n_rst = 1'b0;
      @(posedge clk); #1;

      run_op(16'hFFFF, 16'hFFFF, 1'b0, 0); idle_chk(2);
      run_op(16'hFFFD, 16'h0005, 1'b1, 0); idle_chk(1);
      run_op(16'h8000, 16'h8000, 1'b1, 0); idle_chk(1);
      run_op(16'h7FFF, 16'h8000, 1'b1, 0); idle_chk(1);
      run_op(16'h8000, 16'h8000, 1'b0, 0); idle_chk(1);
`ifdef SEQ_MULT_EARLY_EXIT_EN
      run_op(16'd3, 16'd4, 1'b0, 3); idle_chk(3);
`else
      run_op(16'd3, 16'd4, 1'b0, 5); idle_chk(3);
`endif

      // Asynchronous reset mid-operation
      start = 1'b1; signed_op = 1'b0; src1 = 16'd1000; src2 = 16'd1000;
      @(posedge clk); #1; start = 1'b0;
      repeat (7) @(posedge clk);
      #1 n_rst = 1'b1;
      #1;
      chk("abort_busy", {63'd0, busy}, 64'd0);
      chk("abort_done", {63'd0, done}, 64'd0);
      chk("abort_res", {32'd0, calc_res}, 64'd0);
      @(negedge clk); n_rst = 1'b0;
      last_res = '0;
      idle_chk(20);
      run_op(16'd7, 16'd6, 1'b0, 0); idle_chk(1);

      // Back-to-back: second start issued in the done cycle
      run_op(16'd2, 16'd3, 1'b0, 0);
      run_op(16'd5, 16'd5, 1'b0, 0); idle_chk(1);

      run_op(16'h1234, 16'h0000, 1'b0, 0); idle_chk(1);
      run_op(16'h1234, 16'h0003, 1'b0, 0); idle_chk(1);

      for (int k = 0; k < 40; k++) begin
         run_op(pick(), pick(), 1'($urandom), 0);
         if ($urandom_range(0, 1) == 1) idle_chk(1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
